round_robin_mux_8_1: RTL and testbench
======================================

# round_robin_mux_8_1

Eight-channel, round-robin 8:1 multiplexer with valid/ready handshaking and a registered output. It is the transmit-side counterpart of the 1:8 demultiplexer. Each cycle it picks one requesting input channel, captures that channel's data, and presents it on a single output lane. It also presents the 3-bit channel index, so the output pair (Data_Out, Select_Out) drives a 1:8 DEMUX's Data_In/Select_In directly.

## Interface
- DATA_WIDTH, default 8: width of each channel's data word.
- Clock_In  in  1: single clock; all logic on rising edge.
- Reset_n_In  in  1: reset, synchronous, active-low.
- Enable_In  in  1: high allows new grants; low blocks acceptance.
- Req_In  in  8: per-channel request (valid); bit i belongs to channel i.
- Data_In  in  8*DATA_WIDTH: packed channel data; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- Grant_Out  out  8: one-hot, combinational; bit i high means channel i's word is captured at this rising edge.
- Valid_Out  out  1: registered; the output word is valid.
- Ready_In  in  1: downstream accepts the output word when Valid_Out && Ready_In.
- Data_Out  out  DATA_WIDTH: registered data of the granted channel.
- Select_Out  out  3: registered index of the channel whose data is on Data_Out.
- Lock_In  in  1: present only when RR_MUX_LOCK_EN is defined.

## Operation
- Output stage load condition: load = Enable_In && (!Valid_Out || Ready_In) && (|Req_In).
- Arbitration:
  - Search channels starting at Last_Ptr+1, wrapping 7→0.
  - The first channel with Req_In set wins.
  - The winner's Grant_Out bit is high for that cycle only when load is true; otherwise Grant_Out = 0.
- On load:
  - Data_Out ← winner's word.
  - Select_Out ← winner index.
  - Valid_Out ← 1.
  - Last_Ptr ← winner index.
- Drain: when Valid_Out && Ready_In and no load occurs, Valid_Out ← 0. Data_Out and Select_Out hold their last values.
- Stall: when Valid_Out && !Ready_In, all output registers hold and Grant_Out = 0.
- Requesters must hold Req_In and Data_In stable until granted. Dropping a request before grant is allowed; the arbiter ignores that channel from then on.
- Enable_In low: no grants. An already-valid word still drains normally.

## Timing
- Reset values: Valid_Out = 0, Data_Out = 0, Select_Out = 0, Last_Ptr = 7 (so channel 0 wins first), lock state cleared.
- Reset applied mid-transfer discards the pending word: Valid_Out = 0 on the next edge.
- Latency: Req_In sampled with a grant at edge N → Valid_Out, Data_Out and Select_Out updated after edge N.
- Throughput: one word per cycle while Ready_In stays high (accept and load in the same cycle).
- Fairness: with all 8 channels requesting continuously and Ready_In = 1, the grant order is 0,1,…,7,0,… and each channel waits at most 7 grants.
- A single channel requesting alone is granted every cycle.
- Grant_Out is a combinational function of Req_In, Last_Ptr, Enable_In, Valid_Out and Ready_In. It carries no registered delay.

## Configuration
- RR_MUX_LOCK_EN defined:
  - Lock_In port exists.
  - If Lock_In is high at a load, the lock is set; the lock is held while Lock_In stays high.
  - While locked, only channel Select_Out may be granted, even if others request.
  - The lock releases in the first cycle Lock_In is low, or when the locked channel drops its request; normal round-robin then resumes from Last_Ptr.
- RR_MUX_LOCK_EN undefined: no Lock_In port and no lock logic; pure round-robin.

## Structure
- Shared package rr_mux_pkg:
  - NUM_CH = 8, SEL_W = 3.
  - Reset constant RST_PTR = 3'd7.
  - Function for the packed-index slice.
- Sub-module rr_arbiter_8:
  - Inputs: Req, Last_Ptr, grant enable.
  - Outputs: one-hot grant plus encoded index.
  - Purely combinational; the top level owns Last_Ptr, the output registers and the lock.

## Test plan
- Reset check: Reset_n_In = 0 for 2 cycles with Req_In = 8'hFF → Valid_Out = 0, Grant_Out = 0, Select_Out = 0. After release with Ready_In = 1, the first grant is 8'h01.
- Full rotation: Req_In = 8'hFF, Data_In channel i = 8'h10+i, Ready_In = 1 → Select_Out sequence 0..7,0 and Data_Out sequence 8'h10..8'h17, one per cycle.
- Sparse requests and wrap: Last_Ptr = 6, Req_In = 8'b0000_0101 → grant channel 0 (wraps past 7), then channel 2, then 0.
- Backpressure: Ready_In = 0 while Valid_Out = 1 for 3 cycles → Data_Out and Select_Out stable, Grant_Out = 0. Ready_In = 1 → next channel granted in the same cycle.
- Enable gating: Enable_In = 0 with Req_In = 8'h08 → no grant and Valid_Out drains to 0. Enable_In = 1 → Grant_Out = 8'h08, Select_Out = 3 one cycle later.
- Lock (RR_MUX_LOCK_EN defined): Lock_In = 1 at grant of channel 2 with Req_In = 8'hFF → channel 2 granted 4 consecutive cycles. Lock_In = 0 → next grant is channel 3.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants and the packed-channel slice helper for the round-robin 8:1 mux
package rr_mux_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] RST_PTR = 3'd7;
  function automatic int unsigned ch_lsb(input logic [SEL_W-1:0] ch, input int unsigned w);
    return 32'(ch) * w;
  endfunction
endpackage

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: combinational round-robin pick starting after last_ptr_i, one-hot grant plus index
module rr_arbiter_8
  import rr_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  last_ptr_i,
  input  logic              gnt_en_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [SEL_W-1:0]  idx_o
);
  logic [SEL_W-1:0] ch;
  // scan farthest-to-nearest so the nearest requester after last_ptr_i overwrites the rest
  always_comb begin
    idx_o = '0;
    ch = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      ch = last_ptr_i + SEL_W'(k);
      if (req_i[ch]) idx_o = ch;
    end
    gnt_o = (gnt_en_i && |req_i) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << idx_o) : '0;
  end
endmodule

// File: rtl/round_robin_mux_8_1.sv
// round_robin_mux_8_1: round-robin 8:1 mux with valid/ready output register; RR_MUX_LOCK_EN adds channel lock
module round_robin_mux_8_1
  import rr_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         Clock_In,
  input  logic                         Reset_n_In,
  input  logic                         Enable_In,
  input  logic [NUM_CH-1:0]            Req_In,
  input  logic [NUM_CH*DATA_WIDTH-1:0] Data_In,
  output logic [NUM_CH-1:0]            Grant_Out,
  output logic                         Valid_Out,
  input  logic                         Ready_In,
  output logic [DATA_WIDTH-1:0]        Data_Out,
  output logic [SEL_W-1:0]             Select_Out
`ifdef RR_MUX_LOCK_EN
  ,
  input  logic                         Lock_In
`endif
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0]      sel_q, sel_d, last_q, last_d, win_idx;
  logic [NUM_CH-1:0]     req_eff;
  logic                  load;
`ifdef RR_MUX_LOCK_EN
  logic lock_q, lock_d, locked;
  assign locked  = lock_q && Lock_In && Req_In[sel_q];
  assign req_eff = locked ? (Req_In & ({{(NUM_CH-1){1'b0}}, 1'b1} << sel_q)) : Req_In;
`else
  assign req_eff = Req_In;
`endif
  assign load = Reset_n_In && Enable_In && (!valid_q || Ready_In) && (|req_eff);
  rr_arbiter_8 u_arb (
    .req_i      (req_eff),
    .last_ptr_i (last_q),
    .gnt_en_i   (load),
    .gnt_o      (Grant_Out),
    .idx_o      (win_idx)
  );
  // load the winner, otherwise drain on accept and hold on stall
  always_comb begin
    valid_d = load || (valid_q && !Ready_In);
    data_d  = load ? Data_In[ch_lsb(win_idx, DATA_WIDTH) +: DATA_WIDTH] : data_q;
    sel_d   = load ? win_idx : sel_q;
    last_d  = load ? win_idx : last_q;
`ifdef RR_MUX_LOCK_EN
    lock_d  = load ? Lock_In : locked;
`endif
  end
  // output stage and round-robin pointer registers
  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= RST_PTR;
`ifdef RR_MUX_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
`ifdef RR_MUX_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end
  assign Valid_Out  = valid_q;
  assign Data_Out   = data_q;
  assign Select_Out = sel_q;
endmodule

// File: tb/tb_round_robin_mux_8_1.sv
// tb_round_robin_mux_8_1: directed and randomized checks of round_robin_mux_8_1 against a behavioural model
module tb_round_robin_mux_8_1;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        en = 1;
  logic [7:0]  req = 0;
  logic [63:0] data = 0;
  logic        ready = 1;
  logic        lock = 0;
  logic [7:0]  grant;
  logic        valid;
  logic [7:0]  dout;
  logic [2:0]  sel;
  int tests = 0;
  int fails = 0;
  int  m_last = 7;
  int  m_sel = 0;
  bit  m_valid = 0;
  bit  m_lock = 0;
  logic [7:0] m_data = 0;

  always #5 clk = ~clk;

  round_robin_mux_8_1 #(.DATA_WIDTH(8)) dut (
    .Clock_In   (clk),
    .Reset_n_In (rst_n),
    .Enable_In  (en),
    .Req_In     (req),
    .Data_In    (data),
    .Grant_Out  (grant),
    .Valid_Out  (valid),
    .Ready_In   (ready),
    .Data_Out   (dout),
    .Select_Out (sel)
`ifdef RR_MUX_LOCK_EN
    ,
    .Lock_In    (lock)
`endif
  );

  function automatic logic [7:0] m_req_eff();
    if (m_lock && lock && req[m_sel]) return req & (8'h01 << m_sel);
    return req;
  endfunction

  function automatic int m_pick();
    logic [7:0] r = m_req_eff();
    for (int k = 1; k <= 8; k++) if (r[(m_last + k) % 8]) return (m_last + k) % 8;
    return -1;
  endfunction

  function automatic bit m_load();
    return rst_n && en && (!m_valid || ready) && (m_req_eff() != 0);
  endfunction

  function automatic logic [7:0] m_grant();
    return m_load() ? (8'h01 << m_pick()) : 8'h00;
  endfunction

  task automatic tick();
    bit ld = m_load();
    int w = m_pick();
    bit keep = m_lock && lock && req[m_sel];
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_last = 7; m_lock = 0;
    end else if (ld) begin
      m_data = data[w*8 +: 8]; m_sel = w; m_last = w; m_valid = 1; m_lock = lock;
    end else begin
      m_lock = keep;
      if (m_valid && ready) m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; #1; tick(); rst_n = 1; #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req = 8'hFF; ready = 1; en = 1; #1;
    tick(); tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (grant !== 8'h00) begin fails++; $display("FAIL reset_grant got %h exp 00", grant); end
    tests++; if (sel !== 3'd0) begin fails++; $display("FAIL reset_sel got %0d exp 0", sel); end
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", dout); end
    rst_n = 1; #1;
    tests++; if (grant !== 8'h01) begin fails++; $display("FAIL first_grant got %h exp 01", grant); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < 8; i++) data[i*8 +: 8] = 8'h10 + 8'(i);
    req = 8'hFF; ready = 1; en = 1; #1;
    for (int i = 0; i < 9; i++) begin
      tests++; if (grant !== (8'h01 << (i % 8))) begin fails++; $display("FAIL rot_grant[%0d] got %h exp %h", i, grant, 8'h01 << (i % 8)); end
      tick();
      tests++; if (sel !== 3'(i % 8) || dout !== 8'h10 + 8'(i % 8) || valid !== 1'b1) begin
        fails++; $display("FAIL rot_out[%0d] got sel %0d data %h valid %b exp sel %0d data %h valid 1", i, sel, dout, valid, i % 8, 8'h10 + 8'(i % 8));
      end
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    req = 8'h40; ready = 1; #1; tick();
    req = 8'h05; #1;
    tests++; if (grant !== 8'h01) begin fails++; $display("FAIL wrap_g0 got %h exp 01", grant); end
    tick();
    tests++; if (sel !== 3'd0) begin fails++; $display("FAIL wrap_s0 got %0d exp 0", sel); end
    tests++; if (grant !== 8'h04) begin fails++; $display("FAIL wrap_g2 got %h exp 04", grant); end
    tick();
    tests++; if (sel !== 3'd2) begin fails++; $display("FAIL wrap_s2 got %0d exp 2", sel); end
    tests++; if (grant !== 8'h01) begin fails++; $display("FAIL wrap_g0b got %h exp 01", grant); end
    tick();
    tests++; if (sel !== 3'd0) begin fails++; $display("FAIL wrap_s0b got %0d exp 0", sel); end
  endtask

  task automatic test_backpressure();
    req = 8'hFF; ready = 1; en = 1; #1; tick();
    ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (grant !== 8'h00) begin fails++; $display("FAIL bp_grant[%0d] got %h exp 00", i, grant); end
      tick();
      tests++; if (valid !== 1'b1 || dout !== m_data || sel !== 3'(m_sel)) begin
        fails++; $display("FAIL bp_hold[%0d] got v%b %h/%0d exp v1 %h/%0d", i, valid, dout, sel, m_data, m_sel);
      end
    end
    ready = 1; #1;
    tests++; if (grant !== (8'h01 << ((m_sel + 1) % 8))) begin fails++; $display("FAIL bp_resume got %h exp %h", grant, 8'h01 << ((m_sel + 1) % 8)); end
    tick();
  endtask

  task automatic test_enable();
    en = 0; req = 8'h08; ready = 1; #1;
    tests++; if (grant !== 8'h00) begin fails++; $display("FAIL en_grant got %h exp 00", grant); end
    tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL en_drain got %b exp 0", valid); end
    en = 1; #1;
    tests++; if (grant !== 8'h08) begin fails++; $display("FAIL en_grant_on got %h exp 08", grant); end
    tick();
    tests++; if (sel !== 3'd3 || valid !== 1'b1) begin fails++; $display("FAIL en_sel got %0d v%b exp 3 v1", sel, valid); end
  endtask

`ifdef RR_MUX_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 8'hFF; ready = 1; en = 1; lock = 0; #1;
    tick(); tick();
    lock = 1; #1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (grant !== 8'h04) begin fails++; $display("FAIL lock_grant[%0d] got %h exp 04", i, grant); end
      tick();
    end
    lock = 0; #1;
    tests++; if (grant !== 8'h08) begin fails++; $display("FAIL lock_release got %h exp 08", grant); end
    tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      en    = ($urandom_range(0, 7) != 0);
      ready = ($urandom_range(0, 3) != 0);
      req   = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      data  = {$urandom, $urandom};
`ifdef RR_MUX_LOCK_EN
      lock  = ($urandom_range(0, 2) == 0);
`endif
      #1;
      tests++; if (grant !== m_grant()) begin fails++; $display("FAIL rnd_grant[%0d] got %h exp %h", n, grant, m_grant()); end
      tick();
      tests++; if (valid !== m_valid || dout !== m_data || sel !== 3'(m_sel)) begin
        fails++; $display("FAIL rnd_out[%0d] got v%b %h/%0d exp v%b %h/%0d", n, valid, dout, sel, m_valid, m_data, m_sel);
      end
    end
    rst_n = 1; lock = 0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_sparse_wrap();
    test_backpressure();
    test_enable();
`ifdef RR_MUX_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
